video_frame_counter: RTL and testbench

Timing generator at the head of the video pixel pipeline. Produces the (x, y) frame coordinates consumed by every sprite, obstacle and overlay core, plus the matching hsync/vsync/video_on and frame/line strobes for the VGA output stage. Runs on the system clock with an internal pixel-tick divider. Its sync outputs can be pipeline-delayed to line up with the registered RGB stream leaving the sprite chain.

---
 rtl/video_pkg.sv | 26 ++
 rtl/sync_delay_line.sv | 27 ++
 rtl/video_frame_counter.sv | 138 +++++++++++++
 tb/tb_video_frame_counter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video pipeline definitions: coordinate type, default 640x480 timing
// and colour depth used by the pixel-pipeline cores.
package video_pkg;

  typedef logic [10:0] coord_t;

  // Default 640x480 @ 60 Hz timing
  localparam int HD = 640;
  localparam int HF = 16;
  localparam int HB = 48;
  localparam int HR = 96;
  localparam int VD = 480;
  localparam int VF = 10;
  localparam int VB = 33;
  localparam int VR = 2;

  localparam int CD = 12;

  localparam int COORD_MAX = 2047;

  // Inclusive unsigned range test on coordinates.
  function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Parameterized-depth shift register; every stage resets to RESET_VAL so the
// delayed outputs look idle until real data reaches the end of the line.
module sync_delay_line #(
  parameter int           W         = 1,
  parameter int           DEPTH     = 1,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/video_frame_counter.sv
// Video timing generator: pixel-tick divider, (x, y) counters, line/frame
// strobes and registered sync decode. Define SYNC_DELAY_EN to add SYNC_DLY
// extra register stages on hsync/vsync/video_on.
module video_frame_counter
  import video_pkg::*;
#(
  parameter int HD       = video_pkg::HD,
  parameter int HF       = video_pkg::HF,
  parameter int HB       = video_pkg::HB,
  parameter int HR       = video_pkg::HR,
  parameter int VD       = video_pkg::VD,
  parameter int VF       = video_pkg::VF,
  parameter int VB       = video_pkg::VB,
  parameter int VR       = video_pkg::VR,
  parameter int TICK_DIV = 4,
  parameter int SYNC_DLY = 2
) (
  input  logic        clk,
  input  logic        reset,
  output coord_t      x,
  output coord_t      y,
  output logic        pixel_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int HT = HD + HF + HB + HR;
  localparam int VT = VD + VF + VB + VR;
  localparam int TW = $clog2(TICK_DIV);

  if (HT > COORD_MAX || VT > COORD_MAX) begin : g_bad_total
    $error("video_frame_counter: HT/VT do not fit in 11 bits");
  end
  if (TICK_DIV < 2) begin : g_bad_div
    $error("video_frame_counter: TICK_DIV must be at least 2");
  end
  if (SYNC_DLY < 1) begin : g_bad_dly
    $error("video_frame_counter: SYNC_DLY must be at least 1");
  end

  localparam coord_t X_LAST    = coord_t'(HT - 1);
  localparam coord_t Y_LAST    = coord_t'(VT - 1);
  localparam coord_t X_DISP    = coord_t'(HD);
  localparam coord_t Y_DISP    = coord_t'(VD);
  localparam coord_t H_SYNC_LO = coord_t'(HD + HF);
  localparam coord_t H_SYNC_HI = coord_t'(HD + HF + HR - 1);
  localparam coord_t V_SYNC_LO = coord_t'(VD + VF);
  localparam coord_t V_SYNC_HI = coord_t'(VD + VF + VR - 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_PRE  = TW'(TICK_DIV - 2);

  logic [TW-1:0] tick_cnt;

  // pixel_tick is registered one count early so it is high exactly while
  // tick_cnt == TICK_DIV-1, without a combinational path to the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt   <= '0;
      pixel_tick <= 1'b0;
    end else begin
      tick_cnt   <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
      pixel_tick <= (tick_cnt == TICK_PRE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pixel_tick) begin
        if (x == X_LAST) begin
          x          <= '0;
          line_start <= 1'b1;
          if (y == Y_LAST) begin
            y           <= '0;
            frame_start <= 1'b1;
            frame_cnt   <= frame_cnt + 16'd1;
          end else begin
            y <= y + 11'd1;
          end
        end else begin
          x <= x + 11'd1;
        end
      end
    end
  end

  logic hsync_d, vsync_d, video_on_d;
  logic hsync_r, vsync_r, video_on_r;

  always_comb begin
    hsync_d    = !in_span(x, H_SYNC_LO, H_SYNC_HI);
    vsync_d    = !in_span(y, V_SYNC_LO, V_SYNC_HI);
    video_on_d = (x < X_DISP) && (y < Y_DISP);
  end

  // One register here lines sync up with the 1-clk sprite ROM read downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_r    <= 1'b1;
      vsync_r    <= 1'b1;
      video_on_r <= 1'b0;
    end else begin
      hsync_r    <= hsync_d;
      vsync_r    <= vsync_d;
      video_on_r <= video_on_d;
    end
  end

`ifdef SYNC_DELAY_EN
  sync_delay_line #(
    .W         (3),
    .DEPTH     (SYNC_DLY),
    .RESET_VAL (3'b110)
  ) u_sync_dly (
    .clk   (clk),
    .reset (reset),
    .d     ({hsync_r, vsync_r, video_on_r}),
    .q     ({hsync, vsync, video_on})
  );
`else
  assign hsync    = hsync_r;
  assign vsync    = vsync_r;
  assign video_on = video_on_r;
`endif

endmodule

// File: tb/tb_video_frame_counter.sv
// Self-checking bench: a reduced-timing and a default-timing instance run in
// lockstep against a closed-form model driven by clocks elapsed since reset.
module tb_video_frame_counter;
  import video_pkg::*;

  localparam int S_HD = 16, S_HF = 2, S_HB = 3, S_HR = 4;
  localparam int S_VD = 6,  S_VF = 1, S_VB = 2, S_VR = 2;
  localparam int S_TD = 3;
  localparam int N_CYC = 8000;

`ifdef SYNC_DELAY_EN
  localparam int LAT = 1 + 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct { int hd, hf, hb, hr, vd, vf, vb, vr, td; } tim_t;
  typedef struct { int x, y, pt, hs, vs, vo, ls, fs, fc; } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  coord_t      s_x, s_y, d_x, d_y;
  logic        s_pt, s_hs, s_vs, s_vo, s_ls, s_fs;
  logic        d_pt, d_hs, d_vs, d_vo, d_ls, d_fs;
  logic [15:0] s_fc, d_fc;

  video_frame_counter #(
    .HD(S_HD), .HF(S_HF), .HB(S_HB), .HR(S_HR),
    .VD(S_VD), .VF(S_VF), .VB(S_VB), .VR(S_VR),
    .TICK_DIV(S_TD), .SYNC_DLY(2)
  ) dut_small (
    .clk(clk), .reset(reset), .x(s_x), .y(s_y), .pixel_tick(s_pt),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_vo), .line_start(s_ls),
    .frame_start(s_fs), .frame_cnt(s_fc)
  );

  video_frame_counter dut_def (
    .clk(clk), .reset(reset), .x(d_x), .y(d_y), .pixel_tick(d_pt),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_vo), .line_start(d_ls),
    .frame_start(d_fs), .frame_cnt(d_fc)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int k        = 0;  // clocks since the last reset edge
  int rst_left = 0;
  tim_t ts, tdf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (k=%0d)", tag, got, exp, k);
  endtask

  // Everything follows from k: k/TD pixels have elapsed, and the sync
  // outputs show the pixel from LAT clocks earlier.
  function automatic exp_t model(input tim_t t, input int kk, input int lat);
    exp_t e;
    int ht, vt, p, q, qx, qy;
    ht = t.hd + t.hf + t.hb + t.hr;
    vt = t.vd + t.vf + t.vb + t.vr;
    p = kk / t.td;
    e.x  = p % ht;
    e.y  = (p / ht) % vt;
    e.fc = (p / (ht * vt)) % 65536;
    e.pt = (kk % t.td == t.td - 1) ? 1 : 0;
    e.ls = (kk > 0 && kk % t.td == 0 && e.x == 0) ? 1 : 0;
    e.fs = (e.ls == 1 && e.y == 0) ? 1 : 0;
    if (kk < lat) begin
      e.hs = 1; e.vs = 1; e.vo = 0;
    end else begin
      q  = (kk - lat) / t.td;
      qx = q % ht;
      qy = (q / ht) % vt;
      e.hs = (qx >= t.hd + t.hf && qx < t.hd + t.hf + t.hr) ? 0 : 1;
      e.vs = (qy >= t.vd + t.vf && qy < t.vd + t.vf + t.vr) ? 0 : 1;
      e.vo = (qx < t.hd && qy < t.vd) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic check_unit(input string pfx, input tim_t t,
                            input coord_t ox, input coord_t oy, input logic opt,
                            input logic ohs, input logic ovs, input logic ovo,
                            input logic ols, input logic ofs, input logic [15:0] ofc);
    exp_t e;
    e = model(t, k, LAT);
    check_eq({pfx, "x"},           32'(ox),  e.x);
    check_eq({pfx, "y"},           32'(oy),  e.y);
    check_eq({pfx, "pixel_tick"},  32'(opt), e.pt);
    check_eq({pfx, "hsync"},       32'(ohs), e.hs);
    check_eq({pfx, "vsync"},       32'(ovs), e.vs);
    check_eq({pfx, "video_on"},    32'(ovo), e.vo);
    check_eq({pfx, "line_start"},  32'(ols), e.ls);
    check_eq({pfx, "frame_start"}, 32'(ofs), e.fs);
    check_eq({pfx, "frame_cnt"},   32'(ofc), e.fc);
  endtask

  initial begin
    ts  = '{S_HD, S_HF, S_HB, S_HR, S_VD, S_VF, S_VB, S_VR, S_TD};
    tdf = '{video_pkg::HD, video_pkg::HF, video_pkg::HB, video_pkg::HR,
            video_pkg::VD, video_pkg::VF, video_pkg::VB, video_pkg::VR, 4};
    reset = 1'b1;
    repeat (2) @(posedge clk);
    k = 0;
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      check_unit("small.", ts,  s_x, s_y, s_pt, s_hs, s_vs, s_vo, s_ls, s_fs, s_fc);
      check_unit("def.",   tdf, d_x, d_y, d_pt, d_hs, d_vs, d_vo, d_ls, d_fs, d_fc);
      // Quiet start lets the default instance reach its hsync window and the
      // small one complete several frames; afterwards resets land mid-frame.
      if (rst_left > 0) begin
        reset = 1'b1;
        rst_left--;
      end else begin
        reset = 1'b0;
        if (cyc == 4000 || (cyc > 4500 && $urandom_range(0, 599) == 0)) begin
          reset    = 1'b1;
          rst_left = $urandom_range(0, 2);
        end
      end
      @(posedge clk);
      if (reset) k = 0;
      else k++;
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
